acc_seq_ctrl: RTL and testbench
===============================

ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12, APB address width (4 KB slave window).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum BUSY cycles before abort; legal range 2..65535.
REQ-003 HCLK  in  1  single clock; all state updates on its rising edge.
REQ-004 HRESET  in  1  reset, synchronous and active-high.
REQ-005 PADDR  in  APB_ADDR_WIDTH  APB address; word index = PADDR[11:2].
REQ-006 PWDATA  in  32  APB write data.
REQ-007 PWRITE, PSEL, PENABLE  in  1 each  APB control.
REQ-008 PRDATA  out  32  APB read data, combinational from address.
REQ-009 PREADY  out  1  constant 1.
REQ-010 PSLVERR  out  1  error flag for the current access.
REQ-011 acc_start  out  1  one-cycle start pulse to the accelerator.
REQ-012 acc_done  in  1  accelerator completion pulse; acc_out valid in the same cycle.
REQ-013 acc_in_A, acc_in_B  out  72 each  nine 8-bit operands, element i at bits [8i+7:8i].
REQ-014 acc_out  in  144  nine 16-bit results, element i at bits [16i+15:16i].
REQ-015 irq  out  1  level interrupt = IRQ_EN & (DONE | TIMEOUT).

Function
REQ-016 Register map by word index: 0 CTRL, 1 STATUS, 2-4 A operands, 5-7 B operands, 8-12 results; other indices read 0xFFFFFFFF, writes ignored.
REQ-017 CTRL: bit0 START (write-1 trigger, reads 0), bit1 IRQ_EN (R/W), bit2 CLR (write-1 clears DONE and TIMEOUT, reads 0).
REQ-018 STATUS (read-only): bit0 BUSY, bit1 DONE, bit2 TIMEOUT, bits[15:8] RUN_CNT, all other bits 0.
REQ-019 Operand words pack four bytes LSB-first: word 2 = A0..A3, word 3 = A4..A7, word 4 bits[7:0] = A8; words 5-7 likewise for B; unused bytes are ignored on write and read back as 0.
REQ-020 Result words pack two results: word 8+k bits[15:0] = R[2k], bits[31:16] = R[2k+1]; word 12 bits[31:16] read 0.
REQ-021 A write is accepted in the cycle PSEL & PENABLE & PWRITE; register updates are visible on the next edge.
REQ-022 FSM states: IDLE, START, BUSY, CAPTURE.
REQ-023 IDLE -> START when a START=1 write is accepted; DONE and TIMEOUT are cleared on the same edge.
REQ-024 START: acc_start=1 for exactly one cycle; the timeout counter loads 0; the next state is BUSY.
REQ-025 BUSY: the counter increments each cycle; acc_done=1 -> CAPTURE; otherwise, counter == TIMEOUT_CYCLES-1 -> IDLE with TIMEOUT=1 and results unchanged.
REQ-026 Loading: the result registers load acc_out on the BUSY-cycle edge where acc_done=1.
REQ-027 CAPTURE: DONE=1, RUN_CNT increments (wraps 255->0), next state IDLE; total latency from the accepted START write to DONE visible is 3 cycles + accelerator latency.
REQ-028 BUSY=1 in START, BUSY and CAPTURE.
REQ-029 A START write while BUSY=1 is ignored and returns PSLVERR=1.
REQ-030 Operand writes while BUSY=1 are ignored and return PSLVERR=1.
REQ-031 PSLVERR=0 for all other accesses, including all reads.
REQ-032 acc_done outside BUSY is ignored.
REQ-033 A CLR write and a START write in the same word: START takes effect and flags are cleared.
REQ-034 acc_in_A/acc_in_B drive the operand registers directly and are stable throughout BUSY.

Reset
REQ-035 On HRESET=1 at a clock edge: state=IDLE, all operand and result registers=0, IRQ_EN=0, DONE=0, TIMEOUT=0, RUN_CNT=0, counter=0, acc_start=0.
REQ-036 Reset asserted mid-operation aborts immediately; a later acc_done is ignored and acc_start never pulses until a new START write.

Verification
REQ-037 Write words 2-7 with A=1..9, B=2 each; START; accelerator model returns R[i]=A[i]*B[i] after 5 cycles -> acc_start pulses once, BUSY for 8 cycles, words 8-12 read 0x00040002, 0x00080006, 0x000C000A, 0x0010000E, 0x00000012, STATUS=0x00000102.
REQ-038 Write word 2 while BUSY -> PSLVERR=1, word 2 readback unchanged; a second START while BUSY -> PSLVERR=1, no extra acc_start pulse.
REQ-039 TIMEOUT_CYCLES=16, model never asserts acc_done -> IDLE after 16 BUSY cycles, STATUS bit2=1, results unchanged, irq=1 when IRQ_EN=1.
REQ-040 Run 256 back-to-back jobs -> RUN_CNT reads 0 after wrap; CLR write -> DONE=0, irq=0.
REQ-041 Assert HRESET during BUSY, then pulse acc_done -> all registers 0, STATUS=0x00000000, no capture.
REQ-042 Read word 13 -> 0xFFFFFFFF with PSLVERR=0; stray acc_done in IDLE -> no state change.

Source files
------------

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: APB-programmed sequencer for a 9-lane 8x8 accelerator.
// It holds the operands and results, sends a one-cycle start pulse, waits for
// completion with a timeout guard, and raises a level interrupt when a job ends.
module acc_seq_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      acc_start,
  input  logic                      acc_done,
  output logic [71:0]               acc_in_A,
  output logic [71:0]               acc_in_B,
  input  logic [143:0]              acc_out,
  output logic                      irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t         r_state;
  state_t         w_next_state;
  logic [71:0]    r_op_a;
  logic [71:0]    r_op_b;
  logic [143:0]   r_res;
  logic           r_irq_en;
  logic           r_done;
  logic           r_tout;
  logic [7:0]     r_run_cnt;
  logic [15:0]    r_cnt;

  logic [9:0]     w_widx;
  logic           w_wr;
  logic           w_busy;
  logic           w_op_sel;
  logic           w_start_req;
  logic           w_err;
  logic           w_start_go;
  logic           w_timeout_hit;

  // Word index is the address with the byte offset dropped; upper bits beyond
  // the 4 KB window are ignored by the truncation.
  assign w_widx        = 10'(PADDR >> 2);
  assign w_wr          = PSEL & PENABLE & PWRITE;
  assign w_busy        = (r_state != ST_IDLE);
  assign w_op_sel      = (w_widx >= 10'd2) && (w_widx <= 10'd7);
  assign w_start_req   = (w_widx == 10'd0) && PWDATA[0];
  // Starting or touching operands while a job is in flight is refused whole.
  assign w_err         = w_wr & w_busy & (w_start_req | w_op_sel);
  assign w_start_go    = w_wr & ~w_busy & w_start_req;
  assign w_timeout_hit = (r_cnt == CNT_LAST);

  assign PREADY    = 1'b1;
  assign PSLVERR   = w_err;
  assign acc_start = (r_state == ST_START);
  assign acc_in_A  = r_op_a;
  assign acc_in_B  = r_op_b;
  assign irq       = r_irq_en & (r_done | r_tout);

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; completion takes priority over timeout in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_go) w_next_state = ST_START;
      ST_START:   w_next_state = ST_BUSY;
      ST_BUSY: begin
        if (acc_done)           w_next_state = ST_CAPTURE;
        else if (w_timeout_hit) w_next_state = ST_IDLE;
      end
      ST_CAPTURE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Timeout counter: cleared while the start pulse is out, counts BUSY cycles.
  always_ff @(posedge HCLK) begin
    if (HRESET)                  r_cnt <= 16'd0;
    else if (r_state == ST_START) r_cnt <= 16'd0;
    else if (r_state == ST_BUSY)  r_cnt <= r_cnt + 16'd1;
  end

  // Control and status flags; job-end events are applied after CTRL clears.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_tout    <= 1'b0;
      r_run_cnt <= 8'd0;
    end else begin
      if (w_wr && (w_widx == 10'd0) && !w_err) begin
        r_irq_en <= PWDATA[1];
        if (PWDATA[2] || w_start_go) begin
          r_done <= 1'b0;
          r_tout <= 1'b0;
        end
      end
      if ((r_state == ST_BUSY) && !acc_done && w_timeout_hit) r_tout <= 1'b1;
      if (r_state == ST_CAPTURE) begin
        r_done    <= 1'b1;
        r_run_cnt <= r_run_cnt + 8'd1;
      end
    end
  end

  // Operand registers, writable only while idle; unused upper bytes dropped.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_op_a <= '0;
      r_op_b <= '0;
    end else if (w_wr && w_op_sel && !w_busy) begin
      case (w_widx)
        10'd2:   r_op_a[31:0]  <= PWDATA;
        10'd3:   r_op_a[63:32] <= PWDATA;
        10'd4:   r_op_a[71:64] <= PWDATA[7:0];
        10'd5:   r_op_b[31:0]  <= PWDATA;
        10'd6:   r_op_b[63:32] <= PWDATA;
        10'd7:   r_op_b[71:64] <= PWDATA[7:0];
        default: ;
      endcase
    end
  end

  // Result capture on the BUSY edge where the accelerator reports completion.
  always_ff @(posedge HCLK) begin
    if (HRESET)                                r_res <= '0;
    else if ((r_state == ST_BUSY) && acc_done) r_res <= acc_out;
  end

  // Read mux, purely from the address; holes read all-ones.
  always_comb begin
    PRDATA = 32'hFFFF_FFFF;
    case (w_widx)
      10'd0:  PRDATA = {29'd0, 1'b0, r_irq_en, 1'b0};
      10'd1:  PRDATA = {16'd0, r_run_cnt, 5'd0, r_tout, r_done, w_busy};
      10'd2:  PRDATA = r_op_a[31:0];
      10'd3:  PRDATA = r_op_a[63:32];
      10'd4:  PRDATA = {24'd0, r_op_a[71:64]};
      10'd5:  PRDATA = r_op_b[31:0];
      10'd6:  PRDATA = r_op_b[63:32];
      10'd7:  PRDATA = {24'd0, r_op_b[71:64]};
      10'd8:  PRDATA = r_res[31:0];
      10'd9:  PRDATA = r_res[63:32];
      10'd10: PRDATA = r_res[95:64];
      10'd11: PRDATA = r_res[127:96];
      10'd12: PRDATA = {16'd0, r_res[143:128]};
      default: PRDATA = 32'hFFFF_FFFF;
    endcase
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Testbench for acc_seq_ctrl: register-map table, directed job sequences,
// and randomized traffic against a register-level reference model.
module tb_acc_seq_ctrl;

  localparam int TMO = 16;
  localparam int LAT = 6;

  logic         HCLK = 1'b0;
  logic         HRESET = 1'b1;
  logic [11:0]  PADDR = '0;
  logic [31:0]  PWDATA = '0;
  logic         PWRITE = 1'b0;
  logic         PSEL = 1'b0;
  logic         PENABLE = 1'b0;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic         acc_start;
  logic         acc_done;
  logic [71:0]  acc_in_A;
  logic [71:0]  acc_in_B;
  logic [143:0] acc_out;
  logic         irq;

  acc_seq_ctrl #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .acc_start(acc_start),
    .acc_done(acc_done), .acc_in_A(acc_in_A), .acc_in_B(acc_in_B),
    .acc_out(acc_out), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Accelerator model: answers LAT cycles after the start cycle with lane products.
  int           acc_timer = 0;
  bit           acc_en = 1'b1;
  int           start_pulses = 0;
  logic         model_done = 1'b0;
  logic [143:0] model_out = '0;
  logic         stray_done = 1'b0;
  logic [143:0] stray_val = '0;

  assign acc_done = model_done | stray_done;
  assign acc_out  = stray_done ? stray_val : model_out;

  always @(negedge HCLK) begin
    model_done = 1'b0;
    if (acc_start === 1'b1) begin
      start_pulses++;
      if (acc_en) acc_timer = LAT;
    end else if (acc_timer > 0) begin
      acc_timer--;
      if (acc_timer == 0) begin
        for (int i = 0; i < 9; i++)
          model_out[16*i +: 16] = 16'(acc_in_A[8*i +: 8]) * 16'(acc_in_B[8*i +: 8]);
        model_done = 1'b1;
      end
    end
  end

  // Reference model of the programmer-visible registers.
  logic [7:0]  mA [9];
  logic [7:0]  mB [9];
  logic [15:0] mR [9];
  bit          m_irq_en, m_done, m_tout;
  int          m_run;

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) begin mA[i] = 0; mB[i] = 0; mR[i] = 0; end
    m_irq_en = 0; m_done = 0; m_tout = 0; m_run = 0;
  endfunction

  function automatic logic model_write(input int w, input logic [31:0] d, input bit busy);
    logic e;
    int   idx;
    e = busy && ((w == 0 && d[0]) || (w >= 2 && w <= 7));
    if (!e) begin
      if (w == 0) begin
        m_irq_en = d[1];
        if (d[0] || d[2]) begin m_done = 0; m_tout = 0; end
      end else if (w >= 2 && w <= 7) begin
        for (int j = 0; j < 4; j++) begin
          idx = 4 * ((w - 2) % 3) + j;
          if (idx < 9) begin
            if (w < 5) mA[idx] = d[8*j +: 8];
            else       mB[idx] = d[8*j +: 8];
          end
        end
      end
    end
    return e;
  endfunction

  function automatic void model_job_done();
    for (int i = 0; i < 9; i++) mR[i] = 16'(mA[i]) * 16'(mB[i]);
    m_done = 1;
    m_run  = (m_run + 1) % 256;
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] v;
    int idx;
    v = 32'hFFFF_FFFF;
    if (w == 0) v = {30'd0, m_irq_en, 1'b0};
    else if (w == 1) v = {16'd0, 8'(m_run), 5'd0, m_tout, m_done, 1'b0};
    else if (w >= 2 && w <= 7) begin
      v = '0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * ((w - 2) % 3) + j;
        if (idx < 9) v[8*j +: 8] = (w < 5) ? mA[idx] : mB[idx];
      end
    end else if (w >= 8 && w <= 12) begin
      v = '0;
      idx = 2 * (w - 8);
      v[15:0] = mR[idx];
      if (idx + 1 < 9) v[31:16] = mR[idx + 1];
    end
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apb_write(input int w, input logic [31:0] d, output logic err);
    @(posedge HCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 12'(w * 4); PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1;
    @(negedge HCLK);
    err = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input int w, output logic [31:0] d, output logic err);
    @(posedge HCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 12'(w * 4);
    @(posedge HCLK); #1;
    PENABLE = 1;
    @(negedge HCLK);
    d = PRDATA; err = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic bus_write(input int w, input logic [31:0] d, input bit busy);
    logic e, ee;
    ee = model_write(w, d, busy);
    apb_write(w, d, e);
    check($sformatf("wr_err_w%0d", w), 32'(e), 32'(ee));
  endtask

  task automatic read_check(input int w);
    logic [31:0] d;
    logic e;
    apb_read(w, d, e);
    check($sformatf("rd_w%0d", w), d, exp_word(w));
    check($sformatf("rd_err_w%0d", w), 32'(e), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge HCLK); #1;
    HRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 0;
    model_reset();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    PADDR = 12'h004;
    for (int i = 0; i < TMO + 40; i++) begin
      @(negedge HCLK);
      if (PRDATA[0] == 1'b0) begin ok = 1; break; end
    end
    check("wait_idle", 32'(ok), 32'd1);
  endtask

  // One job: START write, count BUSY cycles, update the model for its outcome.
  task automatic run_job(input bit irqen, input bit accel);
    int p0, cnt;
    acc_en = accel;
    p0 = start_pulses;
    bus_write(0, {30'd0, irqen, 1'b1}, 0);
    PADDR = 12'h004;
    cnt = 0;
    for (int i = 0; i < TMO + 40; i++) begin
      @(negedge HCLK);
      if (PRDATA[0] === 1'b1) cnt++;
      else break;
    end
    if (accel) model_job_done();
    else       m_tout = 1;
    check("busy_cycles", 32'(cnt), accel ? 32'(LAT + 2) : 32'(TMO + 1));
    check("start_pulses", 32'(start_pulses - p0), 32'd1);
    check("irq_after_job", 32'(irq), 32'(m_irq_en & (m_done | m_tout)));
  endtask

  typedef struct {
    int          w;
    bit          wr;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];
  logic [31:0] spec_res [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          p0, op;

    tbl[0]  = '{2,    1, 32'h04030201, 32'h04030201};
    tbl[1]  = '{4,    1, 32'hAABBCC09, 32'h00000009};
    tbl[2]  = '{7,    1, 32'h12345678, 32'h00000078};
    tbl[3]  = '{5,    1, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[4]  = '{13,   0, 32'h0,        32'hFFFFFFFF};
    tbl[5]  = '{13,   1, 32'h00001234, 32'hFFFFFFFF};
    tbl[6]  = '{1023, 0, 32'h0,        32'hFFFFFFFF};
    tbl[7]  = '{0,    1, 32'h00000002, 32'h00000002};
    tbl[8]  = '{0,    1, 32'h00000004, 32'h00000000};
    tbl[9]  = '{1,    1, 32'hFFFFFFFF, 32'h00000000};
    tbl[10] = '{8,    1, 32'hFFFFFFFF, 32'h00000000};
    tbl[11] = '{3,    0, 32'h0,        32'h00000000};
    spec_res[0] = 32'h00040002; spec_res[1] = 32'h00080006;
    spec_res[2] = 32'h000C000A; spec_res[3] = 32'h0010000E;
    spec_res[4] = 32'h00000012;

    // Reset state
    do_reset();
    @(negedge HCLK);
    check("rst_acc_start", 32'(acc_start), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pready", 32'(PREADY), 32'd1);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);
    for (int w = 0; w <= 12; w++) read_check(w);

    // Register map table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].w, tbl[i].d, 0);
      apb_read(tbl[i].w, d, e);
      check($sformatf("tbl%0d_rd", i), d, tbl[i].exp);
      check($sformatf("tbl%0d_rderr", i), 32'(e), 32'd0);
    end

    // Reference job: A=1..9, B=2
    do_reset();
    bus_write(2, 32'h04030201, 0);
    bus_write(3, 32'h08070605, 0);
    bus_write(4, 32'h00000009, 0);
    bus_write(5, 32'h02020202, 0);
    bus_write(6, 32'h02020202, 0);
    bus_write(7, 32'h00000002, 0);
    run_job(0, 1);
    for (int k = 0; k < 5; k++) begin
      apb_read(8 + k, d, e);
      check($sformatf("spec_res%0d", k), d, spec_res[k]);
    end
    apb_read(1, d, e);
    check("spec_status", d, 32'h00000102);

    // Writes refused while busy
    p0 = start_pulses;
    acc_en = 1;
    bus_write(0, 32'h1, 0);
    bus_write(2, 32'hFFFFFFFF, 1);
    bus_write(0, 32'h1, 1);
    wait_idle();
    model_job_done();
    check("busy_err_pulses", 32'(start_pulses - p0), 32'd1);
    read_check(2);
    for (int w = 8; w <= 12; w++) read_check(w);
    read_check(1);

    // Timeout with interrupt enabled
    run_job(1, 0);
    read_check(1);
    for (int w = 8; w <= 12; w++) read_check(w);
    @(negedge HCLK);
    check("tmo_irq", 32'(irq), 32'd1);

    // Hole read and stray completion in idle
    read_check(13);
    p0 = start_pulses;
    stray_val = {$urandom, $urandom, $urandom, $urandom, $urandom};
    @(posedge HCLK); #1 stray_done = 1;
    @(posedge HCLK); #1 stray_done = 0;
    read_check(1);
    for (int w = 8; w <= 12; w++) read_check(w);
    check("stray_pulses", 32'(start_pulses - p0), 32'd0);

    // Reset in the middle of a job; the late completion must be ignored
    acc_en = 1;
    p0 = start_pulses;
    bus_write(0, 32'h1, 0);
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1;
    @(posedge HCLK); #1 HRESET = 0;
    model_reset();
    repeat (10) @(posedge HCLK);
    apb_read(1, d, e);
    check("midrst_status", d, 32'h00000000);
    for (int w = 0; w <= 12; w++) read_check(w);
    check("midrst_pulses", 32'(start_pulses - p0), 32'd1);

    // 256 back-to-back jobs wrap RUN_CNT, then CLR drops the interrupt
    do_reset();
    bus_write(2, 32'h44332211, 0);
    bus_write(6, 32'h0A090807, 0);
    bus_write(0, 32'h2, 0);
    for (int j = 0; j < 256; j++) run_job(1, 1);
    apb_read(1, d, e);
    check("wrap_status", d, 32'h00000002);
    @(negedge HCLK);
    check("wrap_irq", 32'(irq), 32'd1);
    bus_write(0, 32'h6, 0);
    @(negedge HCLK);
    check("clr_irq", 32'(irq), 32'd0);
    read_check(1);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: bus_write($urandom_range(2, 7), $urandom, 0);
        1: run_job(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        2: read_check($urandom_range(0, 15));
        3: bus_write(0, {29'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0}, 0);
        default: begin
          stray_val = {$urandom, $urandom, $urandom, $urandom, $urandom};
          @(posedge HCLK); #1 stray_done = 1;
          @(posedge HCLK); #1 stray_done = 0;
          read_check(1);
          read_check($urandom_range(8, 12));
        end
      endcase
    end
    for (int w = 0; w <= 12; w++) read_check(w);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
